// File: rtl/servo_pkg.sv
// servo_pkg: shared definitions for the servo PWM link.
//   - default timing constants (50 MHz clock, 20 ms frame, 1.0 ms + k*0.14 ms pulses)
//   - position index width and count
//   - width window bound derivation (lower/upper bound for position k)
//   - decoder FSM state encoding
package servo_pkg;

    localparam int PERIOD_DEF  = 1000000;
    localparam int PER_TOL_DEF = 20000;
    localparam int W_MIN_DEF   = 50000;
    localparam int W_STEP_DEF  = 7000;
    localparam int TOL_DEF     = 2000;
    localparam int CNT_W_DEF   = 20;

    localparam int POS_W = 3;
    localparam int N_POS = 8;

    typedef enum logic [1:0] {
        ESPERA_SUBIDA = 2'd0,
        MEDE_ALTO     = 2'd1,
        MEDE_BAIXO    = 2'd2
    } estado_t;

    // Lowest width accepted as position k.
    function automatic logic [31:0] janela_min(input int w_min, input int w_step,
                                               input int tol, input int k);
        return 32'(w_min + k * w_step - tol);
    endfunction

    // Highest width accepted as position k.
    function automatic logic [31:0] janela_max(input int w_min, input int w_step,
                                               input int tol, input int k);
        return 32'(w_min + k * w_step + tol);
    endfunction

endpackage

// File: rtl/detector_borda.sv
// detector_borda: brings an asynchronous input into the clock domain and
// reports its edges.
//   i_clock   : system clock
//   i_reset   : synchronous, active-high reset (all flops go to 1)
//   i_sinal   : asynchronous input
//   o_subida  : one-cycle rise indication (synchronized domain)
//   o_descida : one-cycle fall indication (synchronized domain)
// Resetting to 1 means a line already high at reset release produces no rise.
module detector_borda (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_sinal,
    output logic o_subida,
    output logic o_descida
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Two-stage synchronizer followed by a one-stage history register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= i_sinal;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_subida  = r_s2 & ~r_s3;
    assign o_descida = ~r_s2 & r_s3;

endmodule

// File: rtl/decodificador_pwm_servo.sv
// decodificador_pwm_servo: measures the servo PWM waveform and decodes each
// pulse width back into a 3-bit position index.
//   i_clock          : system clock
//   i_reset          : synchronous, active-high reset
//   i_pwm            : asynchronous PWM line
//   o_posicao        : last validly decoded position (held on errors/timeout)
//   o_valido         : one-cycle pulse per accepted period
//   o_erro_largura   : one-cycle pulse, width outside every position window
//   o_erro_periodo   : one-cycle pulse, period outside PERIOD +/- PER_TOL
//   o_sem_sinal      : level, no rise seen for PERIOD+PER_TOL+1 clocks
module decodificador_pwm_servo
    import servo_pkg::*;
#(
    parameter int PERIOD  = PERIOD_DEF,
    parameter int PER_TOL = PER_TOL_DEF,
    parameter int W_MIN   = W_MIN_DEF,
    parameter int W_STEP  = W_STEP_DEF,
    parameter int TOL     = TOL_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_pwm,
    output logic [POS_W-1:0] o_posicao,
    output logic             o_valido,
    output logic             o_erro_largura,
    output logic             o_erro_periodo,
    output logic             o_sem_sinal
);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(PERIOD + PER_TOL + 1);
    localparam logic [CNT_W-1:0] PER_MIN = CNT_W'(PERIOD - PER_TOL);
    localparam logic [CNT_W-1:0] PER_MAX = CNT_W'(PERIOD + PER_TOL);

    logic             w_subida;
    logic             w_descida;
    logic [N_POS-1:0] w_acerto;
    logic             w_largura_ok;
    logic [POS_W-1:0] w_pos;
    logic             w_periodo_ok;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_largura;
    estado_t          r_estado;
    logic [POS_W-1:0] r_posicao;
    logic             r_valido;
    logic             r_erro_largura;
    logic             r_erro_periodo;
    logic             r_sem_sinal;

    detector_borda u_detector_borda (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_sinal   (i_pwm),
        .o_subida  (w_subida),
        .o_descida (w_descida)
    );

    // Edge-to-edge counter: restarts at 1 on each rise, saturates one past
    // the longest acceptable period so a dead line is recognisable.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (w_subida) begin
            r_cnt <= CNT_W'(1);
        end else if (r_cnt == CNT_SAT) begin
            r_cnt <= r_cnt;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // One window comparator pair per position; windows are disjoint
    // (2*TOL < W_STEP) so at most one bit of w_acerto is ever set.
    for (genvar k = 0; k < N_POS; k++) begin : g_janela
        localparam logic [31:0] LIM_MIN = janela_min(W_MIN, W_STEP, TOL, k);
        localparam logic [31:0] LIM_MAX = janela_max(W_MIN, W_STEP, TOL, k);
        assign w_acerto[k] = (32'(r_largura) >= LIM_MIN) && (32'(r_largura) <= LIM_MAX);
    end

    // One-hot window hit to index: OR of the indices gated by their hit bit.
    always_comb begin
        w_pos = '0;
        for (int k = 0; k < N_POS; k++) begin
            w_pos = w_pos | (POS_W'(k) & {POS_W{w_acerto[k]}});
        end
    end

    assign w_largura_ok = |w_acerto;
    assign w_periodo_ok = (r_cnt >= PER_MIN) && (r_cnt <= PER_MAX);

    // Measurement FSM with registered verdict outputs. Saturation is checked
    // before the rise so a period of exactly PERIOD+PER_TOL+1 takes the
    // timeout path.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_estado       <= ESPERA_SUBIDA;
            r_largura      <= '0;
            r_posicao      <= '0;
            r_valido       <= 1'b0;
            r_erro_largura <= 1'b0;
            r_erro_periodo <= 1'b0;
            r_sem_sinal    <= 1'b1;
        end else begin
            r_valido       <= 1'b0;
            r_erro_largura <= 1'b0;
            r_erro_periodo <= 1'b0;
            case (r_estado)
                ESPERA_SUBIDA: begin
                    if (w_subida) begin
                        r_estado <= MEDE_ALTO;
                    end else begin
                        r_estado <= ESPERA_SUBIDA;
                    end
                end
                MEDE_ALTO: begin
                    if (r_cnt == CNT_SAT) begin
                        r_estado    <= ESPERA_SUBIDA;
                        r_sem_sinal <= 1'b1;
                    end else if (w_descida) begin
                        r_largura <= r_cnt;
                        r_estado  <= MEDE_BAIXO;
                    end else begin
                        r_estado <= MEDE_ALTO;
                    end
                end
                MEDE_BAIXO: begin
                    if (r_cnt == CNT_SAT) begin
                        r_estado    <= ESPERA_SUBIDA;
                        r_sem_sinal <= 1'b1;
                    end else if (w_subida) begin
                        r_estado <= MEDE_ALTO;
                        if (!w_periodo_ok) begin
                            r_erro_periodo <= 1'b1;
                        end else if (!w_largura_ok) begin
                            r_erro_largura <= 1'b1;
                        end else begin
                            r_valido    <= 1'b1;
                            r_posicao   <= w_pos;
                            r_sem_sinal <= 1'b0;
                        end
                    end else begin
                        r_estado <= MEDE_BAIXO;
                    end
                end
                default: begin
                    r_estado <= ESPERA_SUBIDA;
                end
            endcase
        end
    end

    assign o_posicao      = r_posicao;
    assign o_valido       = r_valido;
    assign o_erro_largura = r_erro_largura;
    assign o_erro_periodo = r_erro_periodo;
    assign o_sem_sinal    = r_sem_sinal;

endmodule

// File: tb/tb_decodificador_pwm_servo.sv
// tb_decodificador_pwm_servo: directed bench for the servo PWM decoder.
// Each send() drives one full PWM period and describes the verdict that
// period must earn at the following rise; that verdict is checked during
// the next send() (or an explicit final rise).
module tb_decodificador_pwm_servo;

    logic       clk;
    logic       rst;
    logic       pwm;
    logic [2:0] posicao;
    logic       valido;
    logic       erro_largura;
    logic       erro_periodo;
    logic       sem_sinal;

    int n_cmp;
    int n_err;

    // Pulse counters updated on falling edges (away from the active edge).
    int n_v;
    int n_el;
    int n_ep;
    int s_v;
    int s_el;
    int s_ep;

    // Expected outcome of the period most recently driven.
    int pend_v;
    int pend_el;
    int pend_ep;
    int pend_pos;
    int pend_sem;

    decodificador_pwm_servo #(
        .PERIOD  (1000),
        .PER_TOL (20),
        .W_MIN   (50),
        .W_STEP  (10),
        .TOL     (3),
        .CNT_W   (11)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_pwm          (pwm),
        .o_posicao      (posicao),
        .o_valido       (valido),
        .o_erro_largura (erro_largura),
        .o_erro_periodo (erro_periodo),
        .o_sem_sinal    (sem_sinal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles in which each verdict output is high.
    always @(negedge clk) begin
        if (valido)       n_v  <= n_v + 1;
        if (erro_largura) n_el <= n_el + 1;
        if (erro_periodo) n_ep <= n_ep + 1;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_v  = n_v;
        s_el = n_el;
        s_ep = n_ep;
    endtask

    task automatic chk_pend(input string tag);
        check_eq({tag, ".valido"},       n_v  - s_v,  pend_v);
        check_eq({tag, ".erro_largura"}, n_el - s_el, pend_el);
        check_eq({tag, ".erro_periodo"}, n_ep - s_ep, pend_ep);
        check_eq({tag, ".posicao"},      int'(posicao),   pend_pos);
        check_eq({tag, ".sem_sinal"},    int'(sem_sinal), pend_sem);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_pend(input int v, input int el, input int ep, input int pos, input int sem);
        pend_v   = v;
        pend_el  = el;
        pend_ep  = ep;
        pend_pos = pos;
        pend_sem = sem;
    endtask

    // One period: high h clocks, low p-h clocks. Its rise checks the
    // previous period; the arguments describe this period's verdict.
    task automatic send(input string tag, input int h, input int p,
                        input int v, input int el, input int ep, input int pos, input int sem);
        snap();
        pwm = 1'b1;
        cycles(h);
        pwm = 1'b0;
        chk_pend(tag);
        cycles(p - h);
        set_pend(v, el, ep, pos, sem);
    endtask

    // A lone rise that only checks the pending verdict.
    task automatic flush(input string tag);
        snap();
        pwm = 1'b1;
        cycles(20);
        pwm = 1'b0;
        chk_pend(tag);
        cycles(20);
    endtask

    int sweep_w [15] = '{50, 60, 70, 80, 90, 100, 110, 120, 110, 100, 90, 80, 70, 60, 0};
    int sweep_p [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};

    initial begin
        n_cmp = 0;
        n_err = 0;
        n_v   = 0;
        n_el  = 0;
        n_ep  = 0;
        rst   = 1'b1;
        pwm   = 1'b0;
        set_pend(0, 0, 0, 0, 1);

        // Reset state.
        cycles(3);
        @(negedge clk);
        check_eq("rst.posicao",      int'(posicao),      0);
        check_eq("rst.valido",       int'(valido),       0);
        check_eq("rst.erro_largura", int'(erro_largura), 0);
        check_eq("rst.erro_periodo", int'(erro_periodo), 0);
        check_eq("rst.sem_sinal",    int'(sem_sinal),    1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycles(10);

        // Steady 80-clock pulses: first verdict only at the second rise.
        send("steady0", 80, 1000, 1, 0, 0, 3, 0);
        send("steady1", 80, 1000, 1, 0, 0, 3, 0);

        // Triangle sweep 0..7..1.
        for (int i = 0; i < 14; i++) begin
            send($sformatf("sweep%0d", i), sweep_w[i], 1000, 1, 0, 0, sweep_p[i], 0);
        end

        // Width between windows, and window edges of position 3.
        send("pre85", 80, 1000, 1, 0, 0, 3, 0);
        send("w85",   85, 1000, 0, 1, 0, 3, 0);
        send("w77",   77, 1000, 1, 0, 0, 3, 0);
        send("w83",   83, 1000, 1, 0, 0, 3, 0);

        // Period boundaries.
        send("p979",  80,  979, 0, 0, 1, 3, 0);
        send("p980",  90,  980, 1, 0, 0, 4, 0);
        send("p1020", 70, 1020, 1, 0, 0, 2, 0);
        send("p1021", 80, 1021, 0, 0, 0, 2, 1);
        send("rec0",  80, 1000, 0, 0, 0, 2, 1);
        send("rec1",  80, 1000, 1, 0, 0, 3, 0);

        // Line held low after a last rise: timeout 1021 clocks after detection.
        snap();
        pwm = 1'b1;
        for (int k = 1; k <= 1023; k++) begin
            @(posedge clk);
            #1;
            if (k == 40) chk_pend("last");
            if (k == 80) pwm = 1'b0;
        end
        snap();
        @(negedge clk);
        check_eq("hold.sem_sinal_early", int'(sem_sinal), 0);
        @(negedge clk);
        check_eq("hold.sem_sinal",  int'(sem_sinal), 1);
        check_eq("hold.posicao",    int'(posicao),   3);
        check_eq("hold.no_valido",  n_v - s_v,       0);
        cycles(500);
        set_pend(0, 0, 0, 3, 1);
        send("lost0", 80, 1000, 1, 0, 0, 3, 0);
        send("lost1", 80, 1000, 1, 0, 0, 3, 0);

        // Reset pulsed mid high-phase.
        snap();
        pwm = 1'b1;
        cycles(20);
        chk_pend("prerst");
        cycles(20);
        rst = 1'b1;
        cycles(1);
        @(negedge clk);
        check_eq("midrst.posicao",      int'(posicao),      0);
        check_eq("midrst.valido",       int'(valido),       0);
        check_eq("midrst.erro_largura", int'(erro_largura), 0);
        check_eq("midrst.erro_periodo", int'(erro_periodo), 0);
        check_eq("midrst.sem_sinal",    int'(sem_sinal),    1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycles(38);
        pwm = 1'b0;
        cycles(920);
        set_pend(0, 0, 0, 0, 1);
        send("after0", 80, 1000, 1, 0, 0, 3, 0);
        send("after1", 80, 1000, 1, 0, 0, 3, 0);
        flush("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
